// File: rtl/multdiv_seq_pkg.sv
// ---------------------------------------------------------------------------
// multdiv_seq_pkg
// Shared definitions for the iterative signed multiply/divide unit.
//   - mdState_t : control FSM states (idle, multiplying, dividing, done)
//   - MD_WIDTH  : default operand/result width
//   - cntWidth  : width of the iteration counter for a given operand width
//   - minInt    : most negative two's complement value (for up to 64 bits)
// No ports; this is a package.
// ---------------------------------------------------------------------------
package multdiv_seq_pkg;

   localparam int MD_WIDTH = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } mdState_t;

   // The counter has to hold every value from 0 up to the operand width.
   function automatic int cntWidth(input int width);
      return $clog2(width + 1);
   endfunction

   // Only the sign bit is set. The caller truncates the result to its own width.
   function automatic logic [63:0] minInt(input int width);
      return 64'd1 << (width - 1);
   endfunction

endpackage

// File: rtl/multdiv_addsub.sv
// ---------------------------------------------------------------------------
// multdiv_addsub
// Combinational WIDTH+1 bit adder/subtractor shared by the Booth multiply
// step (add/subtract multiplicand) and the restoring divide step (trial
// subtraction of the divisor).
// Ports:
//   i_a   [WIDTH:0]  first operand
//   i_b   [WIDTH:0]  second operand
//   i_sub            1 = i_a - i_b, 0 = i_a + i_b
//   o_sum [WIDTH:0]  result, wraps modulo 2^(WIDTH+1)
// ---------------------------------------------------------------------------
module multdiv_addsub
   import multdiv_seq_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
)
(
   input  logic [WIDTH:0] i_a,
   input  logic [WIDTH:0] i_b,
   input  logic           i_sub,
   output logic [WIDTH:0] o_sum
);

   // One extra bit of headroom lets the callers work with the magnitude of
   // the most negative operand without wrapping.
   always_comb begin
      o_sum = i_sub ? (i_a - i_b) : (i_a + i_b);
   end

endmodule

// File: rtl/multdiv_seq.sv
// ---------------------------------------------------------------------------
// multdiv_seq
// Iterative signed multiply/divide unit. A start pulse latches the operands.
// WIDTH iterations follow, and a one-cycle done state then registers the
// result and pulses data_resultRDY. The latency is WIDTH+1 edges after the
// start edge.
// Ports:
//   clk             rising-edge clock
//   clr             synchronous active-high reset
//   data_operandA   multiplicand / dividend (signed)
//   data_operandB   multiplier / divisor (signed)
//   ctrl_MULT       start multiply (wins over ctrl_DIV)
//   ctrl_DIV        start divide
//   data_result     low WIDTH product bits, or quotient
//   data_exception  product overflow, divide by zero, or MIN_INT / -1
//   data_resultRDY  one-cycle result-valid pulse
// ---------------------------------------------------------------------------
module multdiv_seq
   import multdiv_seq_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
)
(
   input  logic             clk,
   input  logic             clr,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY
);

   localparam int               CNT_W     = cntWidth(WIDTH);
   localparam logic [WIDTH-1:0] MIN_INT   = WIDTH'(minInt(WIDTH));
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   mdState_t         r_state;
   mdState_t         w_nextState;
   logic [CNT_W-1:0] r_count;
   logic [WIDTH:0]   r_acc;
   logic [WIDTH-1:0] r_lo;
   logic [WIDTH-1:0] r_opnd;
   logic             r_qm1;
   logic             r_isMul;
   logic             r_negQ;
   logic             r_divZero;
   logic             r_divOvf;
   logic [WIDTH-1:0] r_result;
   logic             r_exception;
   logic             r_resultRDY;

   logic             w_start;
   logic             w_mulStep;
   logic             w_divStep;
   logic             w_finish;
   logic [WIDTH:0]   w_addA;
   logic [WIDTH:0]   w_addB;
   logic             w_sub;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_boothAcc;
   logic [WIDTH-1:0] w_magA;
   logic [WIDTH-1:0] w_magB;
   logic [WIDTH-1:0] w_quot;
   logic [WIDTH:0]   w_prodUpper;
   logic             w_mulOvf;

   // The state register. Reset always returns to idle, even in the middle
   // of an operation.
   always_ff @(posedge clk) begin
      if (clr) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic. A start pulse restarts the FSM from any state, so the
   // X stage can abandon an operation it no longer wants. Otherwise the
   // iteration states run until the counter shows the last step.
   always_comb begin
      w_nextState = r_state;
      if (ctrl_MULT) begin
         w_nextState = ST_MUL;
      end else if (ctrl_DIV) begin
         w_nextState = ST_DIV;
      end else begin
         case (r_state)
            ST_MUL, ST_DIV: begin
               if (r_count == LAST_ITER) begin
                  w_nextState = ST_DONE;
               end
            end
            ST_DONE: w_nextState = ST_IDLE;
            default: w_nextState = r_state;
         endcase
      end
   end

   // Datapath controls decoded from the state. A start has priority over
   // everything, so an aborted operation neither steps nor completes.
   always_comb begin
      w_start   = ctrl_MULT | ctrl_DIV;
      w_mulStep = (r_state == ST_MUL)  && !w_start;
      w_divStep = (r_state == ST_DIV)  && !w_start;
      w_finish  = (r_state == ST_DONE) && !w_start;
   end

   // Division works on unsigned magnitudes. Negating MIN_INT gives MIN_INT
   // again, which is exactly 2^(WIDTH-1) when read as unsigned.
   always_comb begin
      w_magA = data_operandA[WIDTH-1] ? (-data_operandA) : data_operandA;
      w_magB = data_operandB[WIDTH-1] ? (-data_operandB) : data_operandB;
   end

   // Adder operand selection.
   // Multiply: accumulator +/- the sign-extended multiplicand.
   // Divide: the remainder shifted left by one, taking the next dividend bit,
   // minus the divisor magnitude.
   always_comb begin
      w_addA = r_acc;
      w_addB = {r_opnd[WIDTH-1], r_opnd};
      w_sub  = r_lo[0] & ~r_qm1;
      if (r_state == ST_DIV) begin
         w_addA = {r_acc[WIDTH-1:0], r_lo[WIDTH-1]};
         w_addB = {1'b0, r_opnd};
         w_sub  = 1'b1;
      end
   end

   multdiv_addsub #(.WIDTH(WIDTH)) u_addsub (
      .i_a   (w_addA),
      .i_b   (w_addB),
      .i_sub (w_sub),
      .o_sum (w_sum)
   );

   // Booth recoding: the pair (multiplier bit, previous bit) equal to 01
   // means add, and 10 means subtract. Equal bits leave the accumulator as
   // it is.
   assign w_boothAcc = (r_lo[0] ^ r_qm1) ? w_sum : r_acc;

   // Final results. A product fits in WIDTH bits only when the top WIDTH+1
   // bits are all copies of the sign. The quotient magnitude is negated
   // when the operand signs differ.
   always_comb begin
      w_prodUpper = {r_acc[WIDTH-1:0], r_lo[WIDTH-1]};
      w_mulOvf    = !((&w_prodUpper) || !(|w_prodUpper));
      w_quot      = r_negQ ? (-r_lo) : r_lo;
   end

   // Shared datapath and output registers.
   // Multiply: {acc, lo, qm1} is shifted right arithmetically after each
   //   Booth add/subtract. After WIDTH steps {acc, lo} holds the product.
   // Divide: acc holds the remainder and lo shifts the dividend out of the
   //   top while quotient bits shift in at the bottom. The trial result is
   //   kept only when it did not go negative.
   // Divide-by-zero still runs the full iteration count so the latency stays
   // fixed; its result is replaced with zero at the end.
   always_ff @(posedge clk) begin
      if (clr) begin
         r_count     <= '0;
         r_acc       <= '0;
         r_lo        <= '0;
         r_opnd      <= '0;
         r_qm1       <= 1'b0;
         r_isMul     <= 1'b0;
         r_negQ      <= 1'b0;
         r_divZero   <= 1'b0;
         r_divOvf    <= 1'b0;
         r_result    <= '0;
         r_exception <= 1'b0;
         r_resultRDY <= 1'b0;
      end else begin
         r_resultRDY <= 1'b0;
         if (w_start) begin
            r_count   <= '0;
            r_acc     <= '0;
            r_qm1     <= 1'b0;
            r_isMul   <= ctrl_MULT;
            r_negQ    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            r_divZero <= (data_operandB == '0);
            r_divOvf  <= (data_operandA == MIN_INT) && (data_operandB == '1);
            if (ctrl_MULT) begin
               r_opnd <= data_operandA;
               r_lo   <= data_operandB;
            end else begin
               r_opnd <= w_magB;
               r_lo   <= w_magA;
            end
         end else if (w_mulStep) begin
            r_acc   <= {w_boothAcc[WIDTH], w_boothAcc[WIDTH:1]};
            r_lo    <= {w_boothAcc[0], r_lo[WIDTH-1:1]};
            r_qm1   <= r_lo[0];
            r_count <= r_count + 1'b1;
         end else if (w_divStep) begin
            r_acc   <= w_sum[WIDTH] ? w_addA : w_sum;
            r_lo    <= {r_lo[WIDTH-2:0], ~w_sum[WIDTH]};
            r_count <= r_count + 1'b1;
         end else if (w_finish) begin
            r_resultRDY <= 1'b1;
            if (r_isMul) begin
               r_result    <= r_lo;
               r_exception <= w_mulOvf;
            end else begin
               r_result    <= r_divZero ? '0 : w_quot;
               r_exception <= r_divZero | r_divOvf;
            end
         end
      end
   end

   assign data_result    = r_result;
   assign data_exception = r_exception;
   assign data_resultRDY = r_resultRDY;

endmodule

// File: tb/tb_multdiv_seq.sv
// ---------------------------------------------------------------------------
// tb_multdiv_seq
// Self-checking bench for multdiv_seq (WIDTH=32). It runs directed cases
// (sign handling, overflow, divide by zero, restart, priority and reset
// mid-operation) and then randomized operations. Random results are checked
// against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_multdiv_seq;

   localparam longint MAX_I32 = 64'sd2147483647;
   localparam longint MIN_I32 = -64'sd2147483648;

   logic        clk = 1'b0;
   logic        clr;
   logic [31:0] data_operandA;
   logic [31:0] data_operandB;
   logic        ctrl_MULT;
   logic        ctrl_DIV;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;

   int totalChecks = 0;
   int badChecks   = 0;

   always #5 clk = ~clk;

   multdiv_seq #(.WIDTH(32)) dut (
      .clk            (clk),
      .clr            (clr),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY)
   );

   // A single comparison point, so every check is counted the same way.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      totalChecks++;
      if (observed !== expected) begin
         badChecks++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Reference model computed from the arithmetic definition with 64-bit math.
   function automatic void refModel(input logic isMul, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] res,
                                    output logic exc);
      longint sa;
      longint sb;
      longint r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (isMul) begin
         r   = sa * sb;
         res = r[31:0];
         exc = (r > MAX_I32) || (r < MIN_I32);
      end else if (sb == 0) begin
         res = 32'h0;
         exc = 1'b1;
      end else if (sa == MIN_I32 && sb == -1) begin
         res = 32'h8000_0000;
         exc = 1'b1;
      end else begin
         r   = sa / sb;
         res = r[31:0];
         exc = 1'b0;
      end
   endfunction

   // Operand generator that often picks values near the edges of the range.
   function automatic logic [31:0] pickOperand();
      case ($urandom_range(0, 5))
         0:       return 32'(int'($urandom_range(0, 40)) - 20);
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h0;
         4:       return 32'd1 << $urandom_range(0, 31);
         default: return $urandom;
      endcase
   endfunction

   // Drive a start pulse. It is set up at the falling edge and sampled by the
   // next rising edge (E0), then removed just after E0.
   task automatic applyStimulus(input logic doMul, input logic doDiv,
                                input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      ctrl_MULT     = doMul;
      ctrl_DIV      = doDiv;
      data_operandA = a;
      data_operandB = b;
      @(posedge clk);
      #1;
      ctrl_MULT = 1'b0;
      ctrl_DIV  = 1'b0;
   endtask

   // Watch a bounded window of edges after E0. Record how many RDY pulses
   // appear and the edge index of the last one.
   task automatic waitResult(output int rdyAt, output int rdyCount,
                             output logic [31:0] res, output logic exc);
      rdyAt    = -1;
      rdyCount = 0;
      res      = 32'h0;
      exc      = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (data_resultRDY) begin
            rdyCount++;
            rdyAt = k;
            res   = data_result;
            exc   = data_exception;
         end
      end
   endtask

   task automatic runOp(input string tag, input logic doMul, input logic doDiv,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expRes, input logic expExc);
      int          rdyAt;
      int          rdyCount;
      logic [31:0] res;
      logic        exc;
      applyStimulus(doMul, doDiv, a, b);
      waitResult(rdyAt, rdyCount, res, exc);
      checkOutput({tag, "_rdyCount"}, 32'(rdyCount), 32'd1);
      checkOutput({tag, "_latency"}, 32'(rdyAt), 32'd33);
      checkOutput({tag, "_result"}, res, expRes);
      checkOutput({tag, "_exc"}, {31'b0, exc}, {31'b0, expExc});
      checkOutput({tag, "_hold"}, data_result, expRes);
   endtask

   // Stop the run if it overruns. A hung DUT still produces a FAIL line.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence.
   initial begin
      int          rdyAt;
      int          rdyCount;
      int          early;
      logic [31:0] res;
      logic        exc;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] expRes;
      logic        expExc;
      int          op;

      clr           = 1'b1;
      ctrl_MULT     = 1'b0;
      ctrl_DIV      = 1'b0;
      data_operandA = 32'h0;
      data_operandB = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_result", data_result, 32'h0);
      checkOutput("reset_exc", {31'b0, data_exception}, 32'h0);
      checkOutput("reset_rdy", {31'b0, data_resultRDY}, 32'h0);
      @(negedge clk);
      clr = 1'b0;

      runOp("mul_3xm4",   1'b1, 1'b0, 32'd3,        32'hFFFF_FFFC, 32'hFFFF_FFF4, 1'b0);
      runOp("mul_ovf",    1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
      runOp("mul_m1xmin", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 1'b1);
      runOp("div_m7by2",  1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0);
      runOp("div_100bym10", 1'b0, 1'b1, 32'd100,    32'hFFFF_FFF6, 32'hFFFF_FFF6, 1'b0);
      runOp("div_5by0",   1'b0, 1'b1, 32'd5,        32'h0,         32'h0,         1'b0 | 1'b1);
      runOp("both_6_3",   1'b1, 1'b1, 32'd6,        32'd3,         32'd18,        1'b0);

      // Start a multiply and replace it with a divide ten edges later. Only
      // the divide may complete.
      applyStimulus(1'b1, 1'b0, 32'd2, 32'd3);
      early = 0;
      for (int k = 1; k <= 9; k++) begin
         @(posedge clk);
         #1;
         if (data_resultRDY) early++;
      end
      applyStimulus(1'b0, 1'b1, 32'd9, 32'd3);
      waitResult(rdyAt, rdyCount, res, exc);
      checkOutput("restart_early_rdy", 32'(early), 32'd0);
      checkOutput("restart_rdyCount", 32'(rdyCount), 32'd1);
      checkOutput("restart_latency", 32'(rdyAt), 32'd33);
      checkOutput("restart_result", res, 32'd3);
      checkOutput("restart_exc", {31'b0, exc}, 32'h0);

      // Leave nonzero outputs behind, then reset in the middle of an operation.
      runOp("div_minbym1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
      applyStimulus(1'b1, 1'b0, 32'd7, 32'd7);
      early = 0;
      for (int k = 1; k <= 14; k++) begin
         @(posedge clk);
         #1;
         if (data_resultRDY) early++;
      end
      @(negedge clk);
      clr = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("midreset_result", data_result, 32'h0);
      checkOutput("midreset_exc", {31'b0, data_exception}, 32'h0);
      checkOutput("midreset_rdy", {31'b0, data_resultRDY}, 32'h0);
      @(negedge clk);
      clr = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (data_resultRDY) early++;
      end
      checkOutput("midreset_no_rdy", 32'(early), 32'd0);
      runOp("post_reset_7x7", 1'b1, 1'b0, 32'd7, 32'd7, 32'd49, 1'b0);

      // Randomized operations checked against the reference model.
      for (int n = 0; n < 30; n++) begin
         op = int'($urandom_range(0, 2));
         a  = pickOperand();
         b  = pickOperand();
         refModel(op != 1, a, b, expRes, expExc);
         runOp($sformatf("rand%0d_op%0d", n, op), op != 1, op != 0, a, b, expRes, expExc);
      end

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
